// File: rtl/watch_time_counter.sv
// Time-of-day counter: divides clk to a centisecond tick and keeps hour:min:sec:centisecond.
// Button set requests are edge-detected and step one field without generating a carry.
module watch_time_counter #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_sec,
  input  logic       btn_min,
  input  logic       btn_hour,
  output logic       tick,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          prev_sec, prev_min, prev_hour;
  logic          inc_sec, inc_min, inc_hour;
  logic          c_ms, c_s, c_m;

  logic [7:0] ms_sum;
  logic [6:0] sec_sum, min_sum;
  logic [5:0] hour_sum;
  logic [6:0] ms_next;
  logic [5:0] sec_next, min_next;
  logic [4:0] hour_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  assign inc_sec  = btn_sec  & ~prev_sec;
  assign inc_min  = btn_min  & ~prev_min;
  assign inc_hour = btn_hour & ~prev_hour;

  // Carries come only from the natural tick chain; a button wrap never ripples.
  assign c_ms = tick & (msec == 7'd99);
  assign c_s  = c_ms & (sec  == 6'd59);
  assign c_m  = c_s  & (min  == 6'd59);

  // Sums are one bit wider than the field; a single subtraction of N reduces them.
  always_comb begin
    ms_sum    = {1'b0, msec} + 8'(tick);
    sec_sum   = {1'b0, sec}  + 7'(c_ms) + 7'(inc_sec);
    min_sum   = {1'b0, min}  + 7'(c_s)  + 7'(inc_min);
    hour_sum  = {1'b0, hour} + 6'(c_m)  + 6'(inc_hour);
    ms_next   = (ms_sum   >= 8'd100) ? 7'(ms_sum   - 8'd100) : ms_sum[6:0];
    sec_next  = (sec_sum  >= 7'd60)  ? 6'(sec_sum  - 7'd60)  : sec_sum[5:0];
    min_next  = (min_sum  >= 7'd60)  ? 6'(min_sum  - 7'd60)  : min_sum[5:0];
    hour_next = (hour_sum >= 6'd24)  ? 5'(hour_sum - 6'd24)  : hour_sum[4:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sec  <= 1'b0;
      prev_min  <= 1'b0;
      prev_hour <= 1'b0;
      msec      <= 7'd0;
      sec       <= 6'd0;
      min       <= 6'd0;
      hour      <= 5'd12;
    end else begin
      prev_sec  <= btn_sec;
      prev_min  <= btn_min;
      prev_hour <= btn_hour;
      msec      <= ms_next;
      sec       <= sec_next;
      min       <= min_next;
      hour      <= hour_next;
    end
  end

endmodule

// File: tb/tb_watch_time_counter.sv
// Bench for watch_time_counter at DIV=10 with a time-of-day reference model
// built on total-centisecond arithmetic plus per-field button steps.
module tb_watch_time_counter;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_sec = 1'b0, btn_min = 1'b0, btn_hour = 1'b0;
  logic       tick;
  logic [6:0] msec;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic [23:0] dut_word;

  int n_pass = 0;
  int n_total = 0;

  int m_h, m_m, m_s, m_ms, m_cyc;
  bit m_tick, p_s, p_m, p_h;
  logic [23:0] exp_q[$];

  watch_time_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk(clk), .rst(rst),
    .btn_sec(btn_sec), .btn_min(btn_min), .btn_hour(btn_hour),
    .tick(tick), .msec(msec), .sec(sec), .min(min), .hour(hour)
  );

  always #5 clk = ~clk;
  assign dut_word = {hour, min, sec, msec};

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  function automatic logic [23:0] tw(input int h, input int m, input int s, input int ms);
    return {5'(h), 6'(m), 6'(s), 7'(ms)};
  endfunction

  function automatic logic [23:0] m_word();
    return tw(m_h, m_m, m_s, m_ms);
  endfunction

  task automatic model_reset();
    m_h = 12; m_m = 0; m_s = 0; m_ms = 0;
    m_tick = 0; m_cyc = 0; p_s = 0; p_m = 0; p_h = 0;
  endtask

  // Reference: a tick advances the whole time of day by one centisecond;
  // a button edge then adds one to its own field modulo that field only.
  task automatic model_step(input bit bs, input bit bm, input bit bh);
    int t;
    bit is, im, ih;
    is = bs && !p_s; im = bm && !p_m; ih = bh && !p_h;
    p_s = bs; p_m = bm; p_h = bh;
    if (m_tick) begin
      t = ((((m_h * 60 + m_m) * 60 + m_s) * 100 + m_ms) + 1) % 8_640_000;
      m_ms = t % 100;
      m_s  = (t / 100) % 60;
      m_m  = (t / 6000) % 60;
      m_h  = t / 360_000;
    end
    m_s = (m_s + int'(is)) % 60;
    m_m = (m_m + int'(im)) % 60;
    m_h = (m_h + int'(ih)) % 24;
    m_tick = (m_cyc % DIV == DIV - 1);
    m_cyc++;
  endtask

  task automatic cycle(input bit bs, input bit bm, input bit bh);
    btn_sec = bs; btn_min = bm; btn_hour = bh;
    @(posedge clk);
    model_step(bs, bm, bh);
    #1;
  endtask

  task automatic pulse(input int which, input int n);
    repeat (n) begin
      cycle(which == 0, which == 1, which == 2);
      cycle(0, 0, 0);
    end
  endtask

  task automatic do_reset();
    btn_sec = 0; btn_min = 0; btn_hour = 0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Idle until the model is in a tick-high cycle with msec at 99.
  task automatic run_to_rollover_edge();
    int guard = 0;
    while (!(m_ms == 99 && m_tick) && guard < 3000) begin
      cycle(0, 0, 0);
      guard++;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    model_reset();
    #1;
    n_total++;
    if (dut_word !== tw(12, 0, 0, 0) || tick !== 1'b0)
      $display("FAIL reset_async: got time %h tick %b, required %h tick 0", dut_word, tick, tw(12, 0, 0, 0));
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (dut_word !== tw(12, 0, 0, 0))
      $display("FAIL reset_release: got %h required %h", dut_word, tw(12, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_prescaler();
    for (int i = 0; i < 31; i++) begin
      cycle(0, 0, 0);
      n_total++;
      if (tick !== (i % 10 == 9))
        $display("FAIL prescaler_tick cycle %0d: got %b required %b", i, tick, (i % 10 == 9));
      else n_pass++;
      if (i == 10 || i == 30) begin
        n_total++;
        if (msec !== ((i == 10) ? 7'd1 : 7'd3))
          $display("FAIL prescaler_msec cycle %0d: got %0d required %0d", i, msec, (i == 10) ? 1 : 3);
        else n_pass++;
      end
    end
  endtask

  task automatic test_carry_chain();
    do_reset();
    pulse(1, 59);
    pulse(0, 59);
    run_to_rollover_edge();
    n_total++;
    if (dut_word !== tw(12, 59, 59, 99))
      $display("FAIL carry_preload: got %h required %h", dut_word, tw(12, 59, 59, 99));
    else n_pass++;
    cycle(0, 0, 0);
    n_total++;
    if (dut_word !== tw(13, 0, 0, 0))
      $display("FAIL carry_chain: got %h required %h", dut_word, tw(13, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_rollover();
    pulse(2, 10);
    pulse(1, 59);
    pulse(0, 59);
    run_to_rollover_edge();
    n_total++;
    if (dut_word !== tw(23, 59, 59, 99))
      $display("FAIL rollover_preload: got %h required %h", dut_word, tw(23, 59, 59, 99));
    else n_pass++;
    cycle(0, 0, 0);
    n_total++;
    if (dut_word !== tw(0, 0, 0, 0))
      $display("FAIL full_rollover: got %h required %h", dut_word, tw(0, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_button_hold();
    do_reset();
    repeat (50) cycle(0, 1, 0);
    cycle(0, 0, 0);
    n_total++;
    if (min !== 6'd1)
      $display("FAIL hold_min: got %0d required 1", min);
    else n_pass++;
  endtask

  task automatic test_sec_wrap();
    do_reset();
    pulse(0, 60);
    n_total++;
    if (sec !== 6'd0 || min !== 6'd0)
      $display("FAIL sec_wrap: got sec %0d min %0d required sec 0 min 0", sec, min);
    else n_pass++;
  endtask

  task automatic test_hour_wrap();
    do_reset();
    pulse(2, 12);
    n_total++;
    if (hour !== 5'd0)
      $display("FAIL hour_wrap: got %0d required 0", hour);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(0, 59);
    run_to_rollover_edge();
    cycle(1, 0, 0);
    n_total++;
    if (sec !== 6'd1 || msec !== 7'd0 || min !== 6'd1 || hour !== 5'd12)
      $display("FAIL simultaneous: got %h required %h", dut_word, tw(12, 1, 1, 0));
    else n_pass++;
    cycle(0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    do_reset();
    pulse(2, 17);
    pulse(1, 17);
    pulse(0, 42);
    while (m_ms != 63 && guard < 2000) begin
      cycle(0, 0, 0);
      guard++;
    end
    n_total++;
    if (dut_word !== tw(5, 17, 42, 63))
      $display("FAIL mid_preload: got %h required %h", dut_word, tw(5, 17, 42, 63));
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (dut_word !== tw(12, 0, 0, 0) || tick !== 1'b0)
      $display("FAIL reset_mid: got time %h tick %b, required %h tick 0", dut_word, tick, tw(12, 0, 0, 0));
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0);
      n_total++;
      if (tick !== (i == 9))
        $display("FAIL reset_mid_tick cycle %0d: got %b required %b", i, tick, (i == 9));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [23:0] exp_w;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      exp_q.push_back(m_word());
      exp_w = exp_q.pop_front();
      n_total++;
      if (dut_word !== exp_w || tick !== m_tick)
        $display("FAIL random cycle %0d: got time %h tick %b, required %h tick %b", i, dut_word, tick, exp_w, m_tick);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_carry_chain();
    test_rollover();
    test_button_hold();
    test_sec_wrap();
    test_hour_wrap();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
